// File: rtl/game_seq_ctrl.sv
// Round sequencer for the memorization game.
// Per round: freeze a random number, show it, open the keyboard window,
// grade the entry, show the result. Tracks score and remaining lives and
// parks in OVER when the last life is lost.
module game_seq_ctrl #(
    parameter int CNT_W         = 30,
    parameter int SHOW_CYCLES   = 500000000,
    parameter int INPUT_CYCLES  = 1000000000,
    parameter int RESULT_CYCLES = 200000000,
    parameter int LIVES         = 3,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btnS,
    input  logic               ready,
    input  logic               correct,
    output logic               latchRand,
    output logic               displayPhase,
    output logic               inputPhase,
    output logic               resultPhase,
    output logic               resultPass,
    output logic               gameOver,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SHOW   = 3'd2,
        S_INPUT  = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_timer;
    logic                 r_btn_prev;
    logic [SCORE_W-1:0]   r_score;
    logic [1:0]           r_lives;
    logic                 r_pass;
    logic [SCORE_W-1:0]   w_score_nxt;
    logic [1:0]           w_lives_nxt;
    logic                 w_start;
    logic                 w_show_done;
    logic                 w_in_done;
    logic                 w_res_done;
    logic                 w_res_entry;
    logic                 w_latch;
    logic                 w_disp;
    logic                 w_inp;
    logic                 w_res;
    logic                 w_over;

    // A held button yields a single start: only the 0->1 transition counts.
    assign w_start     = btnS & ~r_btn_prev;
    assign w_show_done = (r_timer == CNT_W'(SHOW_CYCLES - 1));
    assign w_in_done   = (r_timer == CNT_W'(INPUT_CYCLES - 1));
    assign w_res_done  = (r_timer == CNT_W'(RESULT_CYCLES - 1));
    // Timer is cleared on every state change, so zero marks the first RESULT cycle.
    assign w_res_entry = (r_state == S_RESULT) && (r_timer == '0);

    // State register plus registered phase decodes (aligned with state).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            latchRand    <= 1'b0;
            displayPhase <= 1'b0;
            inputPhase   <= 1'b0;
            resultPhase  <= 1'b0;
            gameOver     <= 1'b0;
        end else begin
            r_state      <= w_next;
            latchRand    <= w_latch;
            displayPhase <= w_disp;
            inputPhase   <= w_inp;
            resultPhase  <= w_res;
            gameOver     <= w_over;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_LATCH;
            S_LATCH:  w_next = S_SHOW;
            S_SHOW:   if (w_show_done) w_next = S_INPUT;
            S_INPUT:  if (ready || w_in_done) w_next = S_RESULT;
            // Use the post-update lives so a 1-cycle RESULT still ends the game.
            S_RESULT: if (w_res_done) w_next = (w_lives_nxt == 2'd0) ? S_OVER : S_LATCH;
            S_OVER:   if (w_start) w_next = S_LATCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // Phase decodes of the upcoming state; registered above.
    always_comb begin
        w_latch = (w_next == S_LATCH);
        w_disp  = (w_next == S_SHOW);
        w_inp   = (w_next == S_INPUT);
        w_res   = (w_next == S_RESULT);
        w_over  = (w_next == S_OVER);
    end

    // Score/lives update: grade applied once on RESULT entry, restore on restart.
    always_comb begin
        w_score_nxt = r_score;
        w_lives_nxt = r_lives;
        if (r_state == S_OVER && w_start) begin
            w_score_nxt = '0;
            w_lives_nxt = 2'(LIVES);
        end else if (w_res_entry) begin
            if (r_pass) begin
                if (!(&r_score)) w_score_nxt = r_score + 1'b1;
            end else if (r_lives != 2'd0) begin
                w_lives_nxt = r_lives - 2'd1;
            end
        end
    end

    // Shared phase timer, start-edge register, grade and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer    <= '0;
            r_btn_prev <= 1'b0;
            r_score    <= '0;
            r_lives    <= 2'(LIVES);
            r_pass     <= 1'b0;
        end else begin
            r_btn_prev <= btnS;
            r_score    <= w_score_nxt;
            r_lives    <= w_lives_nxt;
            if (w_next != r_state)
                r_timer <= '0;
            else if (r_state == S_SHOW || r_state == S_INPUT || r_state == S_RESULT)
                r_timer <= r_timer + 1'b1;
            else
                r_timer <= '0;
            // Ready wins over timeout when both land on the same cycle.
            if (r_state == S_INPUT) begin
                if (ready)
                    r_pass <= correct;
                else if (w_in_done)
                    r_pass <= 1'b0;
            end
        end
    end

    assign resultPass = r_pass;
    assign score      = r_score;
    assign lives      = r_lives;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl with shortened phase timers.
module tb_game_seq_ctrl;

    logic clk, rst, btnS, ready, correct;
    logic latchRand, displayPhase, inputPhase, resultPhase, resultPass, gameOver;
    logic [7:0] score;
    logic [1:0] lives;
    logic s_latch, s_disp, s_inp, s_res, s_pass, s_over;
    logic [1:0] s_score;
    logic [1:0] s_lives;

    int n_vec = 0;
    int n_bad = 0;

    game_seq_ctrl #(.CNT_W(4), .SHOW_CYCLES(4), .INPUT_CYCLES(8), .RESULT_CYCLES(3),
                    .LIVES(2), .SCORE_W(8)) u_dut (
        .clk(clk), .rst(rst), .btnS(btnS), .ready(ready), .correct(correct),
        .latchRand(latchRand), .displayPhase(displayPhase), .inputPhase(inputPhase),
        .resultPhase(resultPhase), .resultPass(resultPass), .gameOver(gameOver),
        .score(score), .lives(lives));

    // Narrow-score copy driven identically, to observe saturation.
    game_seq_ctrl #(.CNT_W(4), .SHOW_CYCLES(4), .INPUT_CYCLES(8), .RESULT_CYCLES(3),
                    .LIVES(2), .SCORE_W(2)) u_sat (
        .clk(clk), .rst(rst), .btnS(btnS), .ready(ready), .correct(correct),
        .latchRand(s_latch), .displayPhase(s_disp), .inputPhase(s_inp),
        .resultPhase(s_res), .resultPass(s_pass), .gameOver(s_over),
        .score(s_score), .lives(s_lives));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in LATCH. rdy_at = INPUT cycle index of the ready
    // pulse, or -1 for a timeout.
    task automatic run_round(input string nm, input int rdy_at, input bit corr,
                             input bit exp_pass, input int exp_score, input int exp_lives);
        int n, k, m, lp, exp_in;
        chk({nm, "_latch"}, latchRand, 1);
        step();
        n = 0; lp = 0;
        while (displayPhase && n < 20) begin
            ready = (n == 1); correct = 1'b1;   // must be ignored in SHOW
            if (latchRand) lp++;
            step();
            n++;
        end
        ready = 1'b0;
        chk({nm, "_show_len"}, n, 4);
        chk({nm, "_show_latch"}, lp, 0);
        chk({nm, "_in_phase"}, inputPhase, 1);
        k = 0;
        while (inputPhase && k < 20) begin
            ready = (k == rdy_at); correct = corr;
            step();
            k++;
        end
        ready = 1'b0; correct = 1'b0;
        exp_in = (rdy_at < 0) ? 8 : rdy_at + 1;
        chk({nm, "_in_len"}, k, exp_in);
        chk({nm, "_res_phase"}, resultPhase, 1);
        chk({nm, "_pass"}, resultPass, exp_pass);
        m = 0;
        while (resultPhase && m < 20) begin
            ready = (m == 0); correct = 1'b1;   // late ready must not regrade
            step();
            m++;
        end
        ready = 1'b0; correct = 1'b0;
        chk({nm, "_res_len"}, m, 3);
        chk({nm, "_score"}, score, exp_score);
        chk({nm, "_lives"}, lives, exp_lives);
        if (exp_lives == 0) chk({nm, "_over"}, gameOver, 1);
        else                chk({nm, "_next_latch"}, latchRand, 1);
    endtask

    initial begin
        rst = 1'b0; btnS = 1'b0; ready = 1'b0; correct = 1'b0;
        step(); step();
        chk("rst_phases", {latchRand, displayPhase, inputPhase, resultPhase, gameOver}, 0);
        chk("rst_pass", resultPass, 0);
        chk("rst_score", score, 0);
        chk("rst_lives", lives, 2);
        rst = 1'b1;
        step(); step();
        chk("idle_hold", {latchRand, displayPhase}, 0);

        // Start with the button held through the whole first round.
        btnS = 1'b1;
        step();
        run_round("r1", 2, 1'b1, 1'b1, 1, 2);
        btnS = 1'b0;
        run_round("r2", 7, 1'b1, 1'b1, 2, 2);   // ready on timeout cycle wins
        run_round("r3", -1, 1'b1, 1'b0, 2, 1);  // timeout
        run_round("r4", 0, 1'b1, 1'b1, 3, 1);
        run_round("r5", 4, 1'b1, 1'b1, 4, 1);
        run_round("r6", 1, 1'b1, 1'b1, 5, 1);
        chk("sat_score", s_score, 3);
        chk("sat_lives", s_lives, 1);

        // Abort mid-INPUT with score=5.
        repeat (5) step();
        chk("pre_abort_in", inputPhase, 1);
        step(); step();
        rst = 1'b0;
        #1;
        chk("abort_phases", {latchRand, displayPhase, inputPhase, resultPhase, gameOver}, 0);
        chk("abort_score", score, 0);
        chk("abort_lives", lives, 2);
        step();
        chk("abort_next", {displayPhase, inputPhase, resultPhase}, 0);
        rst = 1'b1;
        step();

        // Second game: two misses end it.
        btnS = 1'b1;
        step();
        btnS = 1'b0;
        run_round("g2a", 0, 1'b0, 1'b0, 0, 1);
        run_round("g2b", -1, 1'b0, 1'b0, 0, 0);
        repeat (3) step();
        chk("over_hold", gameOver, 1);
        chk("over_no_latch", latchRand, 0);
        btnS = 1'b1;
        step();
        chk("restart_latch", latchRand, 1);
        chk("restart_over", gameOver, 0);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 2);
        btnS = 1'b0;
        run_round("g3", 3, 1'b1, 1'b1, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
